// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples, then resolves one bit per SETTLE_CYCLES+1 cycles, MSB first.
// Latency: done 1+SAMPLE_CYCLES+N*(SETTLE_CYCLES+1) edges after start is sampled; abort cancels to IDLE next edge.
module sar_adc_ctrl #(
    parameter int N             = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         cmp,
    output logic         sample,
    output logic [N-1:0] dac,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [N-1:0]  MSB_SEL     = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t         state;
    logic           cmp_m;
    logic           cmp_s;
    logic           start_seen;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   acc;
    logic [N-1:0]   bit_sel;
    logic [N-1:0]   acc_n;
    logic           in_conv;

    // bit_sel is the one-hot form of the bit index i
    always_comb begin
        acc_n = cmp_s ? (acc | bit_sel) : acc;
    end

    assign in_conv = (state == S_SAMPLE) || (state == S_SETTLE) || (state == S_DECIDE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmp_m      <= 1'b0;
            cmp_s      <= 1'b0;
            start_seen <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            bit_sel    <= '0;
            sample     <= 1'b0;
            dac        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            cmp_m      <= cmp;
            cmp_s      <= cmp_m;
            // start is captured only while idle and only if abort is not also asserted
            start_seen <= (state == S_IDLE) && start && !abort;
            done       <= 1'b0;

            if (abort && in_conv) begin
                state  <= S_IDLE;
                sample <= 1'b0;
                dac    <= '0;
                busy   <= 1'b0;
                cnt    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_seen) begin
                            state   <= S_SAMPLE;
                            sample  <= 1'b1;
                            busy    <= 1'b1;
                            dac     <= '0;
                            acc     <= '0;
                            bit_sel <= MSB_SEL;
                            cnt     <= '0;
                        end
                    end
                    S_SAMPLE: begin
                        if (cnt == SAMPLE_LAST) begin
                            state  <= S_SETTLE;
                            sample <= 1'b0;
                            dac    <= acc | bit_sel;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            state <= S_DECIDE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_DECIDE: begin
                        acc <= acc_n;
                        if (bit_sel[0]) begin
                            state  <= S_DONE;
                            result <= acc_n;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            dac    <= '0;
                        end else begin
                            state   <= S_SETTLE;
                            bit_sel <= bit_sel >> 1;
                            dac     <= acc_n | (bit_sel >> 1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: an 8-bit default instance and a 4-bit instance, each fed by an ideal comparator model.
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       sel = 1'b0;
    logic       abort = 1'b0;
    logic       abort4 = 1'b0;
    logic       tie_en = 1'b0;
    logic       tie_val = 1'b0;
    logic [7:0] vin = 8'h00;

    logic       start, start4, cmp, cmp4;
    logic       sample, busy, done, sample4, busy4, done4;
    logic [7:0] dac, result;
    logic [3:0] dac4, result4;
    logic       o_sample, o_busy, o_done;
    logic [7:0] o_dac, o_result;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign start  = go & ~sel;
    assign start4 = go & sel;
    assign cmp    = tie_en ? tie_val : (vin >= dac);
    assign cmp4   = tie_en ? tie_val : (vin[3:0] >= dac4);

    assign o_sample = sel ? sample4 : sample;
    assign o_busy   = sel ? busy4 : busy;
    assign o_done   = sel ? done4 : done;
    assign o_dac    = sel ? {4'b0000, dac4} : dac;
    assign o_result = sel ? {4'b0000, result4} : result;

    sar_adc_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .cmp    (cmp),
        .sample (sample),
        .dac    (dac),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    sar_adc_ctrl #(.N(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(3)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .abort  (abort4),
        .cmp    (cmp4),
        .sample (sample4),
        .dac    (dac4),
        .busy   (busy4),
        .done   (done4),
        .result (result4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full conversion; expectations come from a plain binary search over the trial codes.
    task automatic conv(input logic s, input logic [7:0] v, input logic toggle, input string tag);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] acc, trial, prev, got;
        int nb, sc, lat, busy_n, done_n, done_at;
        nb = s ? 4 : 8;
        sc = s ? 1 : 4;
        lat = 1 + sc + nb * 4;
        acc = 8'h00;
        for (int b = nb - 1; b >= 0; b--) begin
            trial = acc | (8'd1 << b);
            exp_q.push_back(trial);
            if (v >= trial) acc = trial;
        end
        sel = s;
        vin = v;
        busy_n = 0;
        done_n = 0;
        done_at = -1;
        prev = 8'h00;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        for (int k = 1; k <= lat + 3; k++) begin
            @(posedge clk);
            #1;
            if (toggle && k >= 3 && k <= 30) go = k[0];
            if (o_busy) busy_n++;
            if (o_done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (o_busy && o_dac != 8'h00 && o_dac != prev) got_q.push_back(o_dac);
            prev = o_dac;
            if (k == 1) chk({tag, ".sample_on"}, 32'(o_sample), 32'd1);
            if (k == sc + 1) chk({tag, ".sample_off"}, 32'(o_sample), 32'd0);
            if (k == lat + 1) begin
                chk({tag, ".done_low"}, 32'(o_done), 32'd0);
                chk({tag, ".dac_idle"}, 32'(o_dac), 32'd0);
            end
        end
        go = 1'b0;
        chk({tag, ".done_at"}, 32'(done_at), 32'(lat));
        chk({tag, ".done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(lat - 1));
        chk({tag, ".result"}, 32'(o_result), 32'(acc));
        chk({tag, ".trial_count"}, 32'(got_q.size()), 32'(nb));
        for (int j = 0; j < nb; j++) begin
            got = (j < got_q.size()) ? got_q[j] : 8'hxx;
            chk($sformatf("%s.trial%0d", tag, j), 32'(got), 32'(exp_q[j]));
        end
    endtask

    initial begin
        int nd, d1, d2, busy_seen;
        logic [7:0] r;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.sample", 32'(sample), 32'd0);
        chk("rst.dac", 32'(dac), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        conv(1'b0, 8'hA5, 1'b0, "vin_a5");

        tie_en = 1'b1;
        tie_val = 1'b1;
        conv(1'b0, 8'hFF, 1'b0, "tied1");
        tie_val = 1'b0;
        conv(1'b0, 8'h00, 1'b0, "tied0");
        tie_en = 1'b0;

        conv(1'b0, 8'h5A, 1'b1, "start_toggle");

        for (int n = 0; n < 4; n++) begin
            r = 8'($urandom_range(0, 255));
            conv(1'b0, r, 1'b0, $sformatf("rand%0d", n));
        end

        // abort during bit 4 settle after a 0x3C result
        conv(1'b0, 8'h3C, 1'b0, "pre_abort");
        sel = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        chk("abort.bit4_dac", 32'(dac), 32'h30);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.sample", 32'(sample), 32'd0);
        chk("abort.dac", 32'(dac), 32'd0);
        chk("abort.result", 32'(result), 32'h3C);
        @(negedge clk);
        abort = 1'b0;
        nd = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("abort.no_done", 32'(nd), 32'd0);
        chk("abort.result_held", 32'(result), 32'h3C);

        // abort and start together in IDLE: abort wins
        @(negedge clk);
        go = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        abort = 1'b0;
        busy_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (busy || sample) busy_seen++;
        end
        chk("idle_abort_start.busy", 32'(busy_seen), 32'd0);

        // start held high: back-to-back conversions
        vin = 8'($urandom_range(0, 255));
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        nd = 0;
        d1 = -1;
        d2 = -1;
        for (int k = 1; k <= 82; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k == 38) chk("held.idle_gap_sample", 32'(sample), 32'd0);
            if (k == 77) go = 1'b0;
        end
        chk("held.done1", 32'(d1), 32'd37);
        chk("held.done2", 32'(d2), 32'd76);
        chk("held.done_count", 32'(nd), 32'd2);
        chk("held.result", 32'(result), 32'(vin));

        // asynchronous reset in the middle of the first DECIDE
        vin = 8'hC3;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.sample", 32'(sample), 32'd0);
        chk("async_rst.dac", 32'(dac), 32'd0);
        chk("async_rst.busy", 32'(busy), 32'd0);
        chk("async_rst.done", 32'(done), 32'd0);
        chk("async_rst.result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r = 8'($urandom_range(1, 255));
        conv(1'b0, r, 1'b0, "post_reset");

        conv(1'b1, 8'h09, 1'b0, "n4_vin9");
        for (int n = 0; n < 2; n++) begin
            r = 8'($urandom_range(0, 15));
            conv(1'b1, r, 1'b0, $sformatf("n4_rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
